// File: rtl/npu_out_collector.sv
// Output-side sink for NPUCore: buffers 128-bit result beats in a small FIFO and
// serializes each beat into four 32-bit writes at linearly increasing word addresses.
module npu_out_collector #(
    parameter int PIXELS      = 1024,
    parameter int OUT_CHANNEL = 80,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic [127:0]          NPU_data_in,
    input  logic                  NPU_data_valid_in,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [9:0]            pixel_idx,
    output logic [2:0]            group_idx
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int GROUPS = OUT_CHANNEL / 16;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PIXELS * OUT_CHANNEL / 4 - 1);
    localparam logic [2:0]            LAST_GROUP = 3'(GROUPS - 1);
    localparam logic [9:0]            LAST_PIXEL = 10'(PIXELS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    logic [127:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [127:0]   shift_reg;
    logic [1:0]     word_idx;
    logic [127:0]   fifo_head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           accept;
    logic           pop;
    logic           push;

    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign accept     = (state == SEND) && wr_en && wr_ready;
    // A pop frees a slot on the same edge, so a full FIFO can still take a beat.
    assign pop        = !clr && !fifo_empty &&
                        ((state == IDLE) || (accept && (word_idx == 2'd3)));
    assign push       = !clr && NPU_data_valid_in && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state == SEND);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= NPU_data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (NPU_data_valid_in && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            word_idx   <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            pixel_idx  <= '0;
            group_idx  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            shift_reg  <= '0;
            word_idx   <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            pixel_idx  <= '0;
            group_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                frame_done <= (wr_addr == LAST_ADDR);
                wr_addr    <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_WIDTH'(1);
                if (word_idx == 2'd3) begin
                    if (group_idx == LAST_GROUP) begin
                        group_idx <= '0;
                        pixel_idx <= (pixel_idx == LAST_PIXEL) ? '0 : pixel_idx + 10'd1;
                    end else begin
                        group_idx <= group_idx + 3'd1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= SEND;
                        shift_reg <= fifo_head;
                        word_idx  <= '0;
                        wr_en     <= 1'b1;
                        wr_data   <= fifo_head[31:0];
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (word_idx == 2'd3) begin
                            if (pop) begin
                                shift_reg <= fifo_head;
                                word_idx  <= '0;
                                wr_data   <= fifo_head[31:0];
                            end else begin
                                state <= IDLE;
                                wr_en <= 1'b0;
                            end
                        end else begin
                            word_idx  <= word_idx + 2'd1;
                            shift_reg <= shift_reg >> 32;
                            wr_data   <= shift_reg[63:32];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_out_collector.sv
// Self-checking bench for npu_out_collector: a word scoreboard with a linear address
// model checks every accepted write, plus directed checks for stall, drop, flush and reset.
module tb_npu_out_collector;

    localparam int PIXELS          = 1024;
    localparam int OUT_CHANNEL     = 80;
    localparam int FIFO_DEPTH      = 4;
    localparam int ADDR_WIDTH      = 15;
    localparam int WORDS_PER_PIXEL = OUT_CHANNEL / 4;
    localparam int WORDS_PER_FRAME = PIXELS * WORDS_PER_PIXEL;
    localparam int BEATS_PER_FRAME = WORDS_PER_FRAME / 4;

    logic                  clk;
    logic                  rstn;
    logic                  clr;
    logic [127:0]          NPU_data_in;
    logic                  NPU_data_valid_in;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  wr_ready;
    logic                  busy;
    logic                  frame_done;
    logic                  overflow;
    logic [9:0]            pixel_idx;
    logic [2:0]            group_idx;

    npu_out_collector #(
        .PIXELS      (PIXELS),
        .OUT_CHANNEL (OUT_CHANNEL),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .clr               (clr),
        .NPU_data_in       (NPU_data_in),
        .NPU_data_valid_in (NPU_data_valid_in),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_ready          (wr_ready),
        .busy              (busy),
        .frame_done        (frame_done),
        .overflow          (overflow),
        .pixel_idx         (pixel_idx),
        .group_idx         (group_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          exp_addr;
    bit          expect_done;
    int          done_pulses;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        exp_q.delete();
        exp_addr    = 0;
        expect_done = 1'b0;
    endtask

    // Drives one cycle of inputs; an expected beat is queued as four words, lane 4w in the low byte.
    task automatic applyStimulus(input bit v, input logic [127:0] d, input bit c, input bit expect_push);
        NPU_data_valid_in = v;
        NPU_data_in       = d;
        clr               = c;
        if (v && expect_push && !c) begin
            for (int w = 0; w < 4; w++) exp_q.push_back(d[w*32 +: 32]);
        end
        @(posedge clk);
        #1;
        NPU_data_valid_in = 1'b0;
        clr               = 1'b0;
        if (c) resetModel();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic waitDrain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_remaining_words", exp_q.size(), 0);
    endtask

    function automatic logic [127:0] randBeat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every accepted word must be the oldest expected word at the next linear address.
    always @(negedge clk) begin : monitor
        logic [31:0] word;
        bit          next_done;
        if (rstn) begin
            checkOutput("frame_done", frame_done, expect_done);
            if (frame_done) done_pulses++;
            next_done = 1'b0;
            if (wr_en && wr_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    word = exp_q.pop_front();
                    checkOutput("wr_data", wr_data, word);
                    checkOutput("wr_addr", wr_addr, exp_addr);
                    checkOutput("pixel_idx", pixel_idx, exp_addr / WORDS_PER_PIXEL);
                    checkOutput("group_idx", group_idx, (exp_addr % WORDS_PER_PIXEL) / 4);
                    next_done = (exp_addr == WORDS_PER_FRAME - 1);
                    exp_addr  = next_done ? 0 : exp_addr + 1;
                end
            end
            expect_done = next_done;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [127:0] beat;
        int           hi_cycles;

        rstn              = 1'b0;
        clr               = 1'b0;
        NPU_data_in       = '0;
        NPU_data_valid_in = 1'b0;
        wr_ready          = 1'b1;
        done_pulses       = 0;
        resetModel();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_wr_addr", wr_addr, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_pixel_idx", pixel_idx, 0);
        checkOutput("reset_group_idx", group_idx, 0);
        rstn = 1'b1;
        idleCycles(2);

        $display("[TB] single beat");
        for (int q = 0; q < 16; q++) beat[q*8 +: 8] = 8'(q + 1);
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        exp_q.push_back(32'h100F0E0D);
        applyStimulus(1'b1, beat, 1'b0, 1'b0);
        checkOutput("single_wr_en_after_push", wr_en, 0);
        @(posedge clk);
        #1;
        checkOutput("single_wr_en_first", wr_en, 1);
        checkOutput("single_first_addr", wr_addr, 0);
        checkOutput("single_first_data", wr_data, 32'h04030201);
        hi_cycles = 1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (wr_en) hi_cycles++;
        end
        checkOutput("single_wr_en_cycles", hi_cycles, 4);
        waitDrain(4);

        $display("[TB] full frame");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        done_pulses = 0;
        for (int i = 0; i < BEATS_PER_FRAME; i++) begin
            applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
            idleCycles(3);
        end
        waitDrain(100);
        idleCycles(3);
        checkOutput("frame_done_pulses", done_pulses, 1);
        checkOutput("frame_overflow", overflow, 0);
        checkOutput("frame_wrap_addr", wr_addr, 0);
        checkOutput("frame_wrap_pixel", pixel_idx, 0);
        checkOutput("frame_wrap_group", group_idx, 0);
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        waitDrain(20);

        $display("[TB] backpressure");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        wr_ready = 1'b0;
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_wr_en", wr_en, 1);
            checkOutput("stall_wr_addr", wr_addr, exp_addr);
            checkOutput("stall_wr_data", wr_data, exp_q[0]);
            checkOutput("stall_busy", busy, 1);
            idleCycles(1);
        end
        checkOutput("stall_overflow", overflow, 0);
        wr_ready = 1'b1;
        waitDrain(20);

        $display("[TB] overflow");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, randBeat(), 1'b0, i < 5);
        checkOutput("ovf_set", overflow, 1);
        idleCycles(3);
        wr_ready = 1'b1;
        waitDrain(40);
        idleCycles(2);
        checkOutput("ovf_sticky", overflow, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ovf_cleared", overflow, 0);

        $display("[TB] clr mid-beat");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("clr_pre_addr", wr_addr, 2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("clr_wr_en", wr_en, 0);
        checkOutput("clr_busy", busy, 0);
        checkOutput("clr_wr_addr", wr_addr, 0);
        checkOutput("clr_pixel_idx", pixel_idx, 0);
        checkOutput("clr_group_idx", group_idx, 0);
        idleCycles(3);
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        waitDrain(20);

        $display("[TB] async reset");
        wr_ready = 1'b0;
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("areset_pre_wr_en", wr_en, 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("areset_wr_en", wr_en, 0);
        checkOutput("areset_wr_addr", wr_addr, 0);
        checkOutput("areset_wr_data", wr_data, 0);
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_frame_done", frame_done, 0);
        checkOutput("areset_overflow", overflow, 0);
        checkOutput("areset_pixel_idx", pixel_idx, 0);
        checkOutput("areset_group_idx", group_idx, 0);
        resetModel();
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        wr_ready = 1'b1;
        idleCycles(2);
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
        waitDrain(20);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            wr_ready = ($urandom_range(0, 3) != 0);
            if (((exp_q.size() + 3) / 4) <= 3 && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, randBeat(), 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0);
            end
        end
        wr_ready = 1'b1;
        waitDrain(100);
        idleCycles(2);
        checkOutput("random_overflow", overflow, 0);
        checkOutput("random_busy_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
